// File: rtl/melody_seq.sv
`timescale 1ns/1ps
// melody_seq: plays one of four fixed tunes from an internal ROM on a start pulse.
// Each ROM entry holds a note for len tempo ticks, minus a trailing silent gap.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   start     single-cycle request to play tune song_sel
//   song_sel  tune index, sampled only when start=1
//   stop      abort playback (wins over start)
//   key       registered active-low note code, 8'hFF = silence
//   busy      high while a tune is playing
//   done      one-cycle pulse when a tune completes normally
module melody_seq #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned TICK_DIV   = 3125000,
   parameter int unsigned GAP_CYCLES = 1250000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] song_sel,
   input  logic       stop,
   output logic [7:0] key,
   output logic       busy,
   output logic       done
);

   // Reject timing parameters that would leave no tone or no gap in an entry.
   if (CLK_HZ == 0 || GAP_CYCLES == 0 || GAP_CYCLES >= TICK_DIV) begin : g_param_check
      $error("melody_seq: invalid timing parameters");
   end

   localparam int unsigned CYC_W = $clog2(TICK_DIV);
   localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(TICK_DIV - 1);
   localparam logic [CYC_W-1:0] TONE_LAST = CYC_W'(TICK_DIV - GAP_CYCLES - 1);
   localparam logic [7:0] KEY_SILENT = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_TONE,
      S_GAP,
      S_END
   } state_t;

   // Tune ROM: entry = {note[3:0], len[3:0]}; len=0 terminates the tune.
   function automatic logic [7:0] rom_entry(input logic [1:0] song, input logic [3:0] idx);
      logic [7:0] e;
      case ({song, idx})
         6'h00:   e = 8'h12;
         6'h01:   e = 8'h32;
         6'h02:   e = 8'h54;
         6'h10:   e = 8'hC1;
         6'h11:   e = 8'h81;
         6'h12:   e = 8'h52;
         6'h20:   e = 8'h84;
         6'h21:   e = 8'h74;
         6'h22:   e = 8'h64;
         6'h23:   e = 8'h54;
         6'h24:   e = 8'h18;
         6'h30:   e = 8'h11;
         6'h31:   e = 8'h01;
         6'h32:   e = 8'h82;
         default: e = 8'h00;
      endcase
      return e;
   endfunction

   // Note number to active-low buzzer code; 0 and 15 are rests.
   function automatic logic [7:0] note_key(input logic [3:0] note);
      logic [7:0] k;
      case (note)
         4'd1:    k = 8'hFE;
         4'd2:    k = 8'hFD;
         4'd3:    k = 8'hFB;
         4'd4:    k = 8'hF7;
         4'd5:    k = 8'hEF;
         4'd6:    k = 8'hDF;
         4'd7:    k = 8'hBF;
         4'd8:    k = 8'h7F;
         4'd9:    k = 8'h7E;
         4'd10:   k = 8'h7D;
         4'd11:   k = 8'h7B;
         4'd12:   k = 8'h77;
         4'd13:   k = 8'h6F;
         4'd14:   k = 8'h5F;
         default: k = KEY_SILENT;
      endcase
      return k;
   endfunction

   state_t           state_q, state_d;
   logic [1:0]       song_q, song_d;
   logic [3:0]       idx_q, idx_d;
   logic [3:0]       tick_q, tick_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [7:0]       key_d;
   logic             busy_d;
   logic             done_d;

   logic [7:0]       cur_entry;
   logic [7:0]       nxt_entry;
   logic [7:0]       first_entry;
   logic             tick_end;
   logic             last_tick;
   logic [CYC_W-1:0] cyc_inc;
   logic [3:0]       tick_inc;

   // ROM lookups: current entry, the one after it, and entry 0 of the requested tune.
   always_comb begin
      cur_entry   = rom_entry(song_q, idx_q);
      nxt_entry   = rom_entry(song_q, idx_q + 4'd1);
      first_entry = rom_entry(song_sel, 4'd0);
      tick_end    = (cyc_q == CYC_LAST);
      last_tick   = (tick_q == cur_entry[3:0] - 4'd1);
      cyc_inc     = tick_end ? '0 : cyc_q + CYC_W'(1);
      tick_inc    = tick_end ? tick_q + 4'd1 : tick_q;
   end

   // Next-state and next-output logic; stop has priority over start.
   always_comb begin
      state_d = state_q;
      song_d  = song_q;
      idx_d   = idx_q;
      tick_d  = tick_q;
      cyc_d   = cyc_q;
      key_d   = KEY_SILENT;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      if (stop) begin
         state_d = S_IDLE;
      end else if (start) begin
         song_d = song_sel;
         idx_d  = 4'd0;
         tick_d = 4'd0;
         cyc_d  = '0;
         if (first_entry[3:0] == 4'd0) begin
            state_d = S_END;
            done_d  = 1'b1;
         end else begin
            state_d = S_TONE;
            key_d   = note_key(first_entry[7:4]);
            busy_d  = 1'b1;
         end
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_IDLE;
            end
            S_TONE: begin
               busy_d = 1'b1;
               cyc_d  = cyc_inc;
               tick_d = tick_inc;
               if (last_tick && cyc_q == TONE_LAST) begin
                  state_d = S_GAP;
               end else begin
                  key_d = note_key(cur_entry[7:4]);
               end
            end
            S_GAP: begin
               busy_d = 1'b1;
               cyc_d  = cyc_inc;
               tick_d = tick_inc;
               if (last_tick && tick_end) begin
                  // Index never wraps: entry 15 always ends the tune.
                  if (idx_q == 4'hF || nxt_entry[3:0] == 4'd0) begin
                     state_d = S_END;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_TONE;
                     idx_d   = idx_q + 4'd1;
                     tick_d  = 4'd0;
                     cyc_d   = '0;
                     key_d   = note_key(nxt_entry[7:4]);
                  end
               end
            end
            S_END: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         song_q  <= 2'd0;
         idx_q   <= 4'd0;
         tick_q  <= 4'd0;
         cyc_q   <= '0;
         key     <= KEY_SILENT;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         song_q  <= song_d;
         idx_q   <= idx_d;
         tick_q  <= tick_d;
         cyc_q   <= cyc_d;
         key     <= key_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_melody_seq.sv
`timescale 1ns/1ps
// Bench for melody_seq with TICK_DIV=10, GAP_CYCLES=2.
module tb_melody_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] song_sel;
   logic       stop;
   logic [7:0] key;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   melody_seq #(
      .CLK_HZ    (100),
      .TICK_DIV  (10),
      .GAP_CYCLES(2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .song_sel(song_sel),
      .stop    (stop),
      .key     (key),
      .busy    (busy),
      .done    (done)
   );

   // One record = a run of identical expected output cycles for a tune.
   typedef struct {
      logic [1:0]  song;
      int unsigned cycles;
      logic [7:0]  key;
      logic        busy;
      logic        done;
   } vec_t;

   typedef struct {
      logic [7:0] key;
      logic       busy;
      logic       done;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void add(input logic [1:0] s, input int unsigned c,
                               input logic [7:0] k, input logic b, input logic d);
      vec_t v;
      v.song = s; v.cycles = c; v.key = k; v.busy = b; v.done = d;
      tbl.push_back(v);
   endfunction

   task automatic expect_n(input int unsigned n, input logic [7:0] k, input logic b, input logic d);
      exp_t e;
      e.key = k; e.busy = b; e.done = d;
      repeat (n) exp_q.push_back(e);
   endtask

   task automatic load_song(input logic [1:0] s);
      foreach (tbl[i]) begin
         if (tbl[i].song == s) expect_n(tbl[i].cycles, tbl[i].key, tbl[i].busy, tbl[i].done);
      end
   endtask

   task automatic check(input string name, input exp_t e);
      n_checks++;
      if ({key, busy, done} !== {e.key, e.busy, e.done}) begin
         n_fail++;
         $display("FAIL %s @%0t: got key=%h busy=%b done=%b, expected key=%h busy=%b done=%b",
                  name, $time, key, busy, done, e.key, e.busy, e.done);
      end
   endtask

   // Compare the current cycle against the queue head, then step one cycle.
   task automatic drain(input string name);
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(name, e);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input logic [1:0] s);
      start    = 1'b1;
      song_sel = s;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // tune 0: (1,2) (3,2) (5,4)
      add(0, 18, 8'hFE, 1, 0); add(0, 2, 8'hFF, 1, 0);
      add(0, 18, 8'hFB, 1, 0); add(0, 2, 8'hFF, 1, 0);
      add(0, 38, 8'hEF, 1, 0); add(0, 2, 8'hFF, 1, 0);
      add(0, 1, 8'hFF, 0, 1);  add(0, 2, 8'hFF, 0, 0);
      // tune 1: (12,1) (8,1) (5,2)
      add(1, 8, 8'h77, 1, 0);  add(1, 2, 8'hFF, 1, 0);
      add(1, 8, 8'h7F, 1, 0);  add(1, 2, 8'hFF, 1, 0);
      add(1, 18, 8'hEF, 1, 0); add(1, 2, 8'hFF, 1, 0);
      add(1, 1, 8'hFF, 0, 1);  add(1, 2, 8'hFF, 0, 0);
      // tune 2: (8,4) (7,4) (6,4) (5,4) (1,8)
      add(2, 38, 8'h7F, 1, 0); add(2, 2, 8'hFF, 1, 0);
      add(2, 38, 8'hBF, 1, 0); add(2, 2, 8'hFF, 1, 0);
      add(2, 38, 8'hDF, 1, 0); add(2, 2, 8'hFF, 1, 0);
      add(2, 38, 8'hEF, 1, 0); add(2, 2, 8'hFF, 1, 0);
      add(2, 78, 8'hFE, 1, 0); add(2, 2, 8'hFF, 1, 0);
      add(2, 1, 8'hFF, 0, 1);  add(2, 2, 8'hFF, 0, 0);
      // tune 3: (1,1) (0,1) rest (8,2)
      add(3, 8, 8'hFE, 1, 0);  add(3, 2, 8'hFF, 1, 0);
      add(3, 10, 8'hFF, 1, 0);
      add(3, 18, 8'h7F, 1, 0); add(3, 2, 8'hFF, 1, 0);
      add(3, 1, 8'hFF, 0, 1);  add(3, 2, 8'hFF, 0, 0);

      // Reset held with start asserted.
      rst      = 1'b1;
      start    = 1'b1;
      song_sel = 2'd2;
      stop     = 1'b0;
      @(posedge clk);
      #1;
      expect_n(3, 8'hFF, 0, 0);
      drain("reset");
      rst   = 1'b0;
      start = 1'b0;
      expect_n(3, 8'hFF, 0, 0);
      drain("post_reset");

      // Every tune played start to finish.
      for (int s = 0; s < 4; s++) begin
         pulse_start(2'(s));
         load_song(2'(s));
         drain($sformatf("tune%0d", s));
      end

      // stop at N+25 during tune 2, then tune 1 plays normally.
      pulse_start(2'd2);
      expect_n(24, 8'h7F, 1, 0);
      drain("stop_pre");
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      expect_n(20, 8'hFF, 0, 0);
      drain("stop_post");
      pulse_start(2'd1);
      load_song(2'd1);
      drain("after_stop");

      // Restart tune 1 at N+5 during tune 0.
      pulse_start(2'd0);
      expect_n(4, 8'hFE, 1, 0);
      drain("restart_pre");
      pulse_start(2'd1);
      load_song(2'd1);
      drain("restart");

      // start and stop together from IDLE.
      start    = 1'b1;
      stop     = 1'b1;
      song_sel = 2'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      expect_n(5, 8'hFF, 0, 0);
      drain("start_stop");

      // Reset in the middle of a tone.
      pulse_start(2'd2);
      expect_n(10, 8'h7F, 1, 0);
      drain("rst_mid_pre");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_n(20, 8'hFF, 0, 0);
      drain("rst_mid");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/melody_seq.md
# melody_seq

Sound-effect sequencer for the game audio path. On a start pulse it plays one of four fixed tunes from an internal ROM. It drives the 8-bit active-low note code consumed directly by the downstream buzzer tone generator. Each note is held for a programmable number of tempo ticks, followed by a short silent gap, so repeated notes stay audible.

## Interface
- CLK_HZ, 50000000, system clock frequency (documentation only, no logic depends on it)
- TICK_DIV, 3125000, clock cycles per tempo tick (62.5 ms at 50 MHz)
- GAP_CYCLES, 1250000, silent cycles at the end of every ROM entry; must satisfy 0 < GAP_CYCLES < TICK_DIV
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  single-cycle request to play tune song_sel
- song_sel  input  2  tune index, sampled only in a cycle where start=1
- stop  input  1  abort playback
- key  output  8  active-low note code to the tone generator; 8'hFF means silence
- busy  output  1  high while a tune is playing
- done  output  1  one-cycle pulse when a tune completes normally

## Operation
- ROM entry format: note[3:0] and len[3:0], measured in ticks. len=0 is the terminator. Each tune holds at most 16 entries, indexed 0..15.
- Note-to-key mapping:
  - 1..7 give FE, FD, FB, F7, EF, DF, BF.
  - 8..14 give 7F, 7E, 7D, 7B, 77, 6F, 5F.
  - 0 and 15 are rests and give FF.
- ROM contents, each list ending in a terminator:
  - tune 0: (1,2) (3,2) (5,4)
  - tune 1: (12,1) (8,1) (5,2)
  - tune 2: (8,4) (7,4) (6,4) (5,4) (1,8)
  - tune 3: (1,1) (0,1) (8,2)
- States:
  - IDLE: key=FF, busy=0.
  - TONE: key is the mapped note code.
  - GAP: key=FF.
  - END: one cycle with done=1, busy=0, key=FF; then returns to IDLE.
- Entry duration is len×TICK_DIV cycles in total. The first len×TICK_DIV−GAP_CYCLES cycles are spent in TONE and the last GAP_CYCLES cycles in GAP.
- A rest entry has the same duration, with key=FF throughout.
- After an entry's GAP, the index increments.
  - If the next entry's len is 0, go to END.
  - After entry 15, go to END regardless of contents. The index does not wrap.
- Counters:
  - cycle counter of width clog2(TICK_DIV), wraps every TICK_DIV cycles;
  - 4-bit tick counter;
  - 4-bit entry index.
  - All counters clear on a new start.
- start while busy: restart. The current tune is dropped without a done pulse, and the new song_sel begins exactly as from IDLE.
- stop while busy: on the next cycle the block is in IDLE with key=FF and busy=0. No done pulse.
- stop and start in the same cycle: stop wins and start is ignored.
- stop in IDLE has no effect.
- rst overrides all inputs.

## Timing
- Reset values: key=8'hFF, busy=0, done=0, state IDLE, all counters 0.
- Start sampled at edge N, from IDLE or while busy:
  - From edge N+1, key shows entry 0's code and busy=1.
  - Zero-latency ROM lookup; key is registered.
- For a tune of total length T ticks (the sum of len): busy=1 for cycles N+1 .. N+T×TICK_DIV.
- At cycle N+T×TICK_DIV+1, done=1 and busy=0 in the same cycle.
- At cycle N+T×TICK_DIV+2, done=0.
- An entry with len=0 at index 0 produces END at N+1: a one-cycle done with no sound.
- key changes only on clock edges and has no combinational path from any input.

## Test plan
Parameters for all scenarios: TICK_DIV=10, GAP_CYCLES=2.
- Reset: hold rst for 3 cycles with start=1 → key=FF, busy=0, done=0 throughout and after release.
- Tune 0, start at edge N:
  - FE for N+1..N+18, FF for N+19..N+20;
  - FB for N+21..N+38, FF for N+39..N+40;
  - EF for N+41..N+78, FF for N+79..N+80;
  - done=1 with busy=0 at N+81.
- Tune 3 with a rest: FE for 8 cycles, FF for 2 cycles, FF for 10 cycles (rest), 7F for 18 cycles, FF for 2 cycles; done at N+41.
- stop at cycle N+25 during tune 2 → key=FF and busy=0 at N+26; done never asserts; a later start of tune 1 gives 77 (note 12) at the following cycle.
- Restart: start tune 1 at N+5 during tune 0 → 77 at N+6 with no done for tune 0; tune 1's done at N+5+41. Also, start and stop in the same cycle from IDLE → busy stays 0.
- rst asserted mid-TONE of tune 2 → next cycle key=FF and busy=0; no done pulse.
